// File: rtl/eth_tx_frame_arbiter_if.sv
// AXI-stream bundle of N lanes: N=PORTS on the arbiter ingress, N=1 on its egress.
// Lane i occupies slice i of every vector field.
interface eth_tx_frame_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter into the TX FIFO adapter; truncates and drains frames over MAX_BEATS.
// Zero-latency pass-through while granted, one idle arbitration cycle per frame; m tready goes straight to the owner only.
module eth_tx_frame_arbiter #(
    parameter int                    PORTS                = 2,
    parameter int                    DATA_WIDTH           = 64,
    parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int                    USER_WIDTH           = 1,
    parameter int                    MAX_BEATS            = 190,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    eth_tx_frame_arbiter_if.slave  s_axis,
    eth_tx_frame_arbiter_if.master m_axis,
    output logic [PORTS-1:0]       grant,
    output logic                   status_truncated
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             trunc_q, trunc_d;

    logic                  pick_vld;
    logic [PW-1:0]         pick_idx;
    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  at_limit;

    assign sel_vld  = s_axis.tvalid[gidx_q];
    assign sel_last = s_axis.tlast[gidx_q];
    assign sel_dat  = s_axis.tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep = s_axis.tkeep[int'(gidx_q)*KEEP_WIDTH +: KEEP_WIDTH];
    assign sel_user = s_axis.tuser[int'(gidx_q)*USER_WIDTH +: USER_WIDTH];
    assign at_limit = (beat_cnt_q == CW'(MAX_BEATS - 1));

    // Search starts just after the last owner, so it has lowest priority next round.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= PORTS; k++) begin
            if (!pick_vld && s_axis.tvalid[(int'(rr_ptr_q) + k) % PORTS]) begin
                pick_vld = 1'b1;
                pick_idx = PW'((int'(rr_ptr_q) + k) % PORTS);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        trunc_d       = 1'b0;
        s_axis.tready = '0;
        m_axis.tvalid = '0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = '0;
        m_axis.tuser  = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gidx_d           = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    beat_cnt_d       = '0;
                    state_d          = ACTIVE;
                end
            end
            ACTIVE: begin
                m_axis.tvalid         = sel_vld;
                s_axis.tready[gidx_q] = m_axis.tready;
                m_axis.tdata          = sel_dat;
                m_axis.tkeep          = sel_keep;
                // The beat that reaches the limit without tlast becomes a forced, bad-marked end of frame.
                if (at_limit && !sel_last) begin
                    m_axis.tlast = 1'b1;
                    m_axis.tuser = USER_BAD_FRAME_VALUE;
                end else begin
                    m_axis.tlast = sel_last;
                    m_axis.tuser = sel_user;
                end
                if (sel_vld && m_axis.tready) begin
                    if (beat_cnt_q != CW'(MAX_BEATS)) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (sel_last) begin
                        rr_ptr_d = gidx_q;
                        grant_d  = '0;
                        state_d  = IDLE;
                    end else if (at_limit) begin
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_axis.tready[gidx_q] = 1'b1;
                if (sel_vld && sel_last) begin
                    rr_ptr_d = gidx_q;
                    grant_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PW'(PORTS - 1);
            gidx_q     <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    assign grant            = grant_q;
    assign status_truncated = trunc_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench: dut_a (MAX_BEATS=8) covers arbitration, backpressure and reset;
// dut_b (MAX_BEATS=4) covers truncation and the exact-limit frame. Both see identical stimulus.
module tb_eth_tx_frame_arbiter;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic        chk_gap;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic m_rdy;
    logic dsel;
    logic        s_vld  [2];
    logic [63:0] s_dat  [2];
    logic [7:0]  s_keep [2];
    logic        s_last [2];
    logic        s_user [2];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_end_cyc = 0;
    int    trunc_cnt = 0;
    bit    bp_done;
    beat_t exp_q[$];

    logic [1:0] grant_a, grant_b;
    logic       trunc_a, trunc_b;

    eth_tx_frame_arbiter_if #(.N(2), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1)) sa_if ();
    eth_tx_frame_arbiter_if #(.N(1), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1)) ma_if ();
    eth_tx_frame_arbiter_if #(.N(2), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1)) sb_if ();
    eth_tx_frame_arbiter_if #(.N(1), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1)) mb_if ();

    assign sa_if.tdata  = {s_dat[1], s_dat[0]};
    assign sa_if.tkeep  = {s_keep[1], s_keep[0]};
    assign sa_if.tvalid = {s_vld[1], s_vld[0]};
    assign sa_if.tlast  = {s_last[1], s_last[0]};
    assign sa_if.tuser  = {s_user[1], s_user[0]};
    assign sb_if.tdata  = {s_dat[1], s_dat[0]};
    assign sb_if.tkeep  = {s_keep[1], s_keep[0]};
    assign sb_if.tvalid = {s_vld[1], s_vld[0]};
    assign sb_if.tlast  = {s_last[1], s_last[0]};
    assign sb_if.tuser  = {s_user[1], s_user[0]};
    assign ma_if.tready = m_rdy;
    assign mb_if.tready = m_rdy;

    eth_tx_frame_arbiter #(.PORTS(2), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1),
                           .MAX_BEATS(8), .USER_BAD_FRAME_VALUE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .s_axis(sa_if), .m_axis(ma_if),
        .grant(grant_a), .status_truncated(trunc_a));

    eth_tx_frame_arbiter #(.PORTS(2), .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1),
                           .MAX_BEATS(4), .USER_BAD_FRAME_VALUE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .s_axis(sb_if), .m_axis(mb_if),
        .grant(grant_b), .status_truncated(trunc_b));

    logic [1:0]  sel_srdy, sel_grant;
    logic        sel_mvld, sel_mlast, sel_muser, sel_trunc;
    logic [63:0] sel_mdat;
    logic [7:0]  sel_mkeep;
    assign sel_srdy  = dsel ? sb_if.tready    : sa_if.tready;
    assign sel_grant = dsel ? grant_b         : grant_a;
    assign sel_mvld  = dsel ? mb_if.tvalid[0] : ma_if.tvalid[0];
    assign sel_mlast = dsel ? mb_if.tlast[0]  : ma_if.tlast[0];
    assign sel_muser = dsel ? mb_if.tuser[0]  : ma_if.tuser[0];
    assign sel_mdat  = dsel ? mb_if.tdata     : ma_if.tdata;
    assign sel_mkeep = dsel ? mb_if.tkeep     : ma_if.tkeep;
    assign sel_trunc = dsel ? trunc_b         : trunc_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bdat(input int p, input int f, input int b);
        return {8'hA5, 24'h0, 8'(p), 8'(f), 16'(b)};
    endfunction

    // Expected egress of an n-beat frame through an arbiter limited to maxb beats.
    task automatic push_frame(input int p, input int f, input int n, input logic ulast,
                              input int maxb, input bit gap);
        int m;
        beat_t e;
        m = (n < maxb) ? n : maxb;
        for (int b = 0; b < m; b++) begin
            e.dat     = bdat(p, f, b);
            e.keep    = (b == n - 1) ? 8'h0F : 8'hFF;
            e.last    = (b == n - 1);
            e.user    = (b == n - 1) ? ulast : 1'b0;
            e.chk_gap = gap && (b == 0);
            if (b == maxb - 1 && b != n - 1) begin
                e.last = 1'b1;
                e.user = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input int p, input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic u);
        bit ok;
        int n;
        s_vld[p] = 1'b1; s_dat[p] = d; s_keep[p] = k; s_last[p] = l; s_user[p] = u;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = sel_srdy[p];
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout port %0d: no ready in %0d cycles, expected ready", p, n);
        end
        s_vld[p] = 1'b0; s_dat[p] = '0; s_keep[p] = '0; s_last[p] = 1'b0; s_user[p] = 1'b0;
    endtask

    task automatic drive_frame(input int p, input int f, input int n, input logic ulast);
        for (int b = 0; b < n; b++)
            send_beat(p, bdat(p, f, b), (b == n - 1) ? 8'h0F : 8'hFF,
                      (b == n - 1), (b == n - 1) ? ulast : 1'b0);
    endtask

    // Monitor: pops one expected beat per egress handshake of the selected DUT.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && sel_trunc) trunc_cnt++;
            if (!rst && sel_mvld && m_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", sel_mdat, sel_mlast);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", sel_mdat, e.dat);
                    check("beat_keep", 64'(sel_mkeep), 64'(e.keep));
                    check("beat_last", 64'(sel_mlast), 64'(e.last));
                    check("beat_user", 64'(sel_muser), 64'(e.user));
                    if (e.chk_gap) check("frame_gap", 64'(cyc - last_end_cyc), 64'd2);
                    if (sel_mlast) last_end_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int start;
        int t0;
        for (int i = 0; i < 2; i++) begin
            s_vld[i] = 1'b0; s_dat[i] = '0; s_keep[i] = '0; s_last[i] = 1'b0; s_user[i] = 1'b0;
        end
        m_rdy = 1'b1;
        dsel  = 1'b0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 64'(sel_grant), 64'd0);
        check("rst_s_tready", 64'(sel_srdy), 64'd0);
        check("rst_m_tvalid", 64'(sel_mvld), 64'd0);
        check("rst_m_tdata", sel_mdat, 64'd0);
        check("rst_m_tlast", 64'(sel_mlast), 64'd0);
        check("rst_m_tuser", 64'(sel_muser), 64'd0);
        check("rst_truncated", 64'(sel_trunc), 64'd0);
        rst = 1'b0;

        // Contention: both ports stream two 3-beat frames each; expect 0,1,0,1.
        push_frame(0, 0, 3, 1'b0, 8, 1'b0);
        push_frame(1, 0, 3, 1'b0, 8, 1'b1);
        push_frame(0, 1, 3, 1'b0, 8, 1'b1);
        push_frame(1, 1, 3, 1'b0, 8, 1'b1);
        fork
            begin drive_frame(0, 0, 3, 1'b0); drive_frame(0, 1, 3, 1'b0); end
            begin drive_frame(1, 0, 3, 1'b0); drive_frame(1, 1, 3, 1'b0); end
        join
        check("contention_idle_grant", 64'(sel_grant), 64'd0);
        check("contention_sb_empty", 64'(exp_q.size()), 64'd0);

        // Single port 4-beat frame: one idle arbitration cycle, grant 01 while active.
        repeat (2) @(posedge clk);
        #1;
        push_frame(0, 2, 4, 1'b0, 8, 1'b0);
        start = cyc;
        send_beat(0, bdat(0, 2, 0), 8'hFF, 1'b0, 1'b0);
        check("single_arb_latency", 64'(cyc - start), 64'd2);
        check("single_grant_b0", 64'(sel_grant), 64'd1);
        send_beat(0, bdat(0, 2, 1), 8'hFF, 1'b0, 1'b0);
        send_beat(0, bdat(0, 2, 2), 8'hFF, 1'b0, 1'b0);
        check("single_grant_b2", 64'(sel_grant), 64'd1);
        send_beat(0, bdat(0, 2, 3), 8'h0F, 1'b1, 1'b0);
        check("single_idle_after", 64'(sel_grant), 64'd0);

        // Backpressure: m tready toggles each cycle across a 5-beat frame.
        push_frame(0, 3, 5, 1'b1, 8, 1'b0);
        bp_done = 1'b0;
        fork
            begin drive_frame(0, 3, 5, 1'b1); bp_done = 1'b1; end
            begin
                for (int n = 0; n < 60 && !bp_done; n++) begin
                    @(posedge clk);
                    #1;
                    m_rdy = ~m_rdy;
                    #1;
                    if (sel_grant == 2'b01) begin
                        check("bp_owner_tready", 64'(sel_srdy[0]), 64'(m_rdy));
                        check("bp_other_tready", 64'(sel_srdy[1]), 64'd0);
                    end
                end
            end
        join
        m_rdy = 1'b1;
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Async reset in the middle of a frame, after two beats have gone out.
        @(posedge clk);
        #1;
        push_frame(0, 4, 2, 1'b0, 8, 1'b0);
        exp_q[exp_q.size() - 1].last = 1'b0;
        exp_q[exp_q.size() - 1].keep = 8'hFF;
        send_beat(0, bdat(0, 4, 0), 8'hFF, 1'b0, 1'b0);
        send_beat(0, bdat(0, 4, 1), 8'hFF, 1'b0, 1'b0);
        s_vld[0] = 1'b1; s_dat[0] = bdat(0, 4, 2); s_keep[0] = 8'hFF;
        s_vld[1] = 1'b1; s_dat[1] = bdat(1, 4, 0); s_keep[1] = 8'hFF;
        #1;
        rst = 1'b1;
        #1;
        check("arst_grant", 64'(sel_grant), 64'd0);
        check("arst_m_tvalid", 64'(sel_mvld), 64'd0);
        check("arst_m_tdata", sel_mdat, 64'd0);
        check("arst_m_tkeep", 64'(sel_mkeep), 64'd0);
        check("arst_m_tlast", 64'(sel_mlast), 64'd0);
        check("arst_s_tready", 64'(sel_srdy), 64'd0);
        check("arst_sb_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 2; i++) begin
            s_vld[i] = 1'b0; s_dat[i] = '0; s_keep[i] = '0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_frame(0, 5, 2, 1'b0, 8, 1'b0);
        push_frame(1, 5, 2, 1'b1, 8, 1'b1);
        fork
            drive_frame(0, 5, 2, 1'b0);
            drive_frame(1, 5, 2, 1'b1);
            begin
                @(posedge clk);
                #2;
                check("post_reset_first_grant", 64'(sel_grant), 64'd1);
            end
        join
        check("post_reset_sb_empty", 64'(exp_q.size()), 64'd0);

        // Switch to the MAX_BEATS=4 instance from a clean reset.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        dsel = 1'b1;

        // Oversize: port 1 sends 7 beats; 4 go out, last forced and bad, rest drained.
        t0 = trunc_cnt;
        push_frame(1, 6, 7, 1'b0, 4, 1'b0);
        drive_frame(1, 6, 7, 1'b0);
        check("oversize_idle_grant", 64'(sel_grant), 64'd0);
        check("oversize_trunc_pulses", 64'(trunc_cnt - t0), 64'd1);
        check("oversize_sb_empty", 64'(exp_q.size()), 64'd0);

        // Exactly MAX_BEATS with tlast on the last beat is a legal frame.
        @(posedge clk);
        #1;
        t0 = trunc_cnt;
        push_frame(0, 7, 4, 1'b0, 4, 1'b0);
        drive_frame(0, 7, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("boundary_trunc_pulses", 64'(trunc_cnt - t0), 64'd0);
        check("boundary_sb_empty", 64'(exp_q.size()), 64'd0);
        check("final_grant", 64'(sel_grant), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
